// File: rtl/win_text_sequencer_if.sv
// Control and reveal-count bundle for the win-scene text sequencer.
// The slave side is the sequencer; the master side is the scene/frame logic driving it.
`timescale 1ns/1ps

interface win_text_sequencer_if;
    logic       start;
    logic       frame_tick;
    logic       skip;
    logic [3:0] line0_chars;
    logic [3:0] line1_chars;
    logic [3:0] line2_chars;
    logic       busy;
    logic       done;
    logic       blink_on;

    modport master (
        output start, frame_tick, skip,
        input  line0_chars, line1_chars, line2_chars, busy, done, blink_on
    );

    modport slave (
        input  start, frame_tick, skip,
        output line0_chars, line1_chars, line2_chars, busy, done, blink_on
    );
endinterface

// File: rtl/win_text_sequencer.sv
// Typewriter reveal of the three win-scene text lines, paced by frame ticks,
// followed by a blinking "press to continue" phase once all lines are shown.
`timescale 1ns/1ps

module win_text_sequencer #(
    parameter int CHAR_TICKS  = 6,
    parameter int LINE_GAP    = 20,
    parameter int BLINK_TICKS = 30,
    parameter int LEN0        = 6,
    parameter int LEN1        = 3,
    parameter int LEN2        = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    win_text_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_TYPE,
        S_GAP,
        S_DONE
    } state_e;

    localparam logic [7:0]       CHAR_LAST  = 8'(CHAR_TICKS - 1);
    localparam logic [7:0]       GAP_LAST   = 8'(LINE_GAP - 1);
    localparam logic [7:0]       BLINK_LAST = 8'(BLINK_TICKS - 1);
    localparam logic [2:0][3:0]  LEN_C      = {4'(LEN2), 4'(LEN1), 4'(LEN0)};

    state_e          state_q, state_d;
    logic [1:0]      cur_q,   cur_d;
    logic [7:0]      tick_q,  tick_d;
    logic [2:0][3:0] cnt_q,   cnt_d;
    logic            blink_q, blink_d;
    logic            busy_q,  busy_d;
    logic            done_q,  done_d;
    logic [3:0]      cnt_inc;

    // NOTE: every variable gets its hold value first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        tick_d  = tick_q;
        cnt_d   = cnt_q;
        blink_d = blink_q;
        cnt_inc = cnt_q[cur_q] + 4'd1;

        if (bus.start) begin
            // Restart from any state; a coincident skip or frame_tick is dropped.
            state_d = S_TYPE;
            cur_d   = 2'd0;
            tick_d  = 8'd0;
            cnt_d   = '0;
            blink_d = 1'b0;
        end else if (bus.skip && (state_q == S_TYPE || state_q == S_GAP)) begin
            state_d = S_DONE;
            tick_d  = 8'd0;
            cnt_d   = LEN_C;
            blink_d = 1'b0;
        end else if (bus.frame_tick) begin
            unique case (state_q)
                S_TYPE: begin
                    if (tick_q == CHAR_LAST) begin
                        tick_d        = 8'd0;
                        cnt_d[cur_q]  = cnt_inc;
                        if (cnt_inc == LEN_C[cur_q]) begin
                            state_d = (cur_q == 2'd2) ? S_DONE : S_GAP;
                            blink_d = 1'b0;
                        end
                    end else begin
                        tick_d = tick_q + 8'd1;
                    end
                end
                S_GAP: begin
                    if (tick_q == GAP_LAST) begin
                        tick_d  = 8'd0;
                        cur_d   = cur_q + 2'd1;
                        state_d = S_TYPE;
                    end else begin
                        tick_d = tick_q + 8'd1;
                    end
                end
                S_DONE: begin
                    if (tick_q == BLINK_LAST) begin
                        tick_d  = 8'd0;
                        blink_d = ~blink_q;
                    end else begin
                        tick_d = tick_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end

        // Status flags are computed from the next state so they register alongside it.
        busy_d = (state_d == S_TYPE) || (state_d == S_GAP);
        done_d = (state_d == S_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cur_q   <= 2'd0;
            tick_q  <= 8'd0;
            cnt_q   <= '0;
            blink_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            tick_q  <= tick_d;
            cnt_q   <= cnt_d;
            blink_q <= blink_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.line0_chars = cnt_q[0];
    assign bus.line1_chars = cnt_q[1];
    assign bus.line2_chars = cnt_q[2];
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.blink_on    = blink_q;

endmodule
